// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus.
// One outstanding transfer at a time, with a watchdog that terminates hung transfers.
module picosoc_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam bit              WD_EN  = (TIMEOUT_CYCLES > 0);
  localparam int              TMAX_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMAX  = CNT_W'(TMAX_I);

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic        w_busy;
  logic        w_sel1;
  logic        w_mvalid;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rdata;

  assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_sel1    = (r_state == BUSY1);
  assign w_mvalid  = w_sel1 ? m1_valid : m0_valid;
  // A real s_ready in the final watchdog cycle wins over the timeout.
  assign w_timeout = WD_EN && w_busy && !s_ready && (r_cnt == TMAX);
  assign w_done    = w_busy && (s_ready || w_timeout);
  assign w_rdata   = s_ready ? s_rdata : 32'd0;

  assign s_valid = w_busy && w_mvalid && !w_timeout;
  assign s_instr = w_busy && (w_sel1 ? m1_instr : m0_instr);
  assign s_addr  = w_busy ? (w_sel1 ? m1_addr  : m0_addr)  : 32'd0;
  assign s_wdata = w_busy ? (w_sel1 ? m1_wdata : m0_wdata) : 32'd0;
  assign s_wstrb = w_busy ? (w_sel1 ? m1_wstrb : m0_wstrb) : 4'd0;

  assign m0_ready = (r_state == BUSY0) && w_done;
  assign m1_ready = (r_state == BUSY1) && w_done;
  assign m0_rdata = m0_ready ? w_rdata : 32'd0;
  assign m1_rdata = m1_ready ? w_rdata : 32'd0;

  assign grant         = {r_state == BUSY1, r_state == BUSY0};
  assign timeout_pulse = w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_valid && m1_valid)
            r_state <= r_last ? BUSY0 : BUSY1;
          else if (m0_valid)
            r_state <= BUSY0;
          else if (m1_valid)
            r_state <= BUSY1;
        end
        BUSY0, BUSY1: begin
          // A master dropping valid early is abandoned without touching fairness.
          if (w_done) begin
            r_last  <= w_sel1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_mvalid) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (WD_EN && (r_cnt != TMAX)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/picosoc_bus_arbiter.md
Name: picosoc_bus_arbiter

Overview:
- Two-master arbiter for the PicoRV32 native memory bus (valid/ready, addr/wdata/wstrb/rdata, instr).
- Shares one downstream memory bus between master 0 (CPU) and master 1 (DMA/debug requester).
- Downstream is the SoC address decoder (RAM, SPI flash, cfg register, iomem).
- Round-robin fairness, one outstanding transaction, watchdog timeout that terminates hung transfers.

Parameters:
- TIMEOUT_CYCLES, 1023: BUSY cycles without s_ready before forced termination; 0 disables the watchdog.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- m0_valid  input  1  master 0 request
- m0_instr  input  1  master 0 instruction-fetch flag
- m0_addr  input  32  master 0 address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 byte strobes; 0 = read
- m0_ready  output  1  master 0 transfer complete
- m0_rdata  output  32  master 0 read data
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for master 1
- s_valid  output  1  downstream request
- s_instr  output  1  downstream instr flag
- s_addr  output  32  downstream address
- s_wdata  output  32  downstream write data
- s_wstrb  output  4  downstream strobes
- s_ready  input  1  downstream completion
- s_rdata  input  32  downstream read data
- grant  output  2  one-hot current owner; 00 = idle
- timeout_pulse  output  1  one-cycle pulse on watchdog termination

Behaviour:
- Reset values:
  - State = IDLE; grant = 00; last = 1, so master 0 wins the first tie.
  - Counter = 0; all outputs 0, including s_valid, m*_ready and timeout_pulse.
- Reset mid-transaction aborts immediately; no ready is issued to either master.
- FSM states: IDLE, BUSY0, BUSY1.
- IDLE:
  - If exactly one mN_valid is high, go to BUSYN.
  - If both are high, grant the master other than last.
  - If neither is high, stay in IDLE.
  - The grant is registered: s_valid is first asserted the cycle after the request is seen.
  - Arbitration latency is one cycle.
- BUSYN:
  - s_valid = mN_valid.
  - s_instr/addr/wdata/wstrb = mN_* (combinational mux on the registered grant).
  - mN_ready = s_ready.
  - mN_rdata = s_rdata while mN_ready is high, else 0.
  - The non-granted master's ready = 0 and rdata = 0; its s_* inputs are ignored.
- Completion: s_ready high in BUSYN causes:
  - last <= N, state <= IDLE, counter <= 0.
  - The next grant starts one cycle later, so back-to-back transfers have a minimum one-cycle bubble.
- Masters must hold valid and payload stable until ready.
  - If mN_valid drops in BUSYN with s_ready low (protocol violation): return to IDLE, do not update last, no ready issued.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter increments each BUSY cycle while s_ready is low.
  - When counter == TIMEOUT_CYCLES-1 and s_ready is low:
    - mN_ready = 1 and mN_rdata = 0 in that cycle.
    - s_valid is forced to 0 in that cycle.
    - timeout_pulse = 1 for that cycle.
    - last <= N, state <= IDLE.
  - If s_ready and the timeout fall in the same cycle, s_ready wins: normal completion with s_rdata, no pulse.
  - The counter saturates at TIMEOUT_CYCLES-1 and never wraps.
- s_ready seen while in IDLE is ignored; no master ready.
- s_wstrb is driven only in BUSY; it is 0 in IDLE, so no spurious downstream writes.

Test Plan:
- Single master: m0 reads 0x0000_0100; slave returns ready 2 cycles after s_valid with rdata 0xDEADBEEF.
  - Expect: grant = 01 one cycle after m0_valid; m0_ready for one cycle with m0_rdata = 0xDEADBEEF; m1_ready stays 0.
- Simultaneous requests: m0 and m1 both assert valid from reset; slave has 1-cycle ready.
  - Expect grant order 01, 10, 01, 10; exactly one idle cycle between grants.
- Write routing: m1 writes 0x1234_5678 to 0x0200_0000 with wstrb = 0011 while m0 is idle.
  - Expect s_addr = 0x0200_0000, s_wdata = 0x1234_5678, s_wstrb = 0011 only while grant = 10.
- Timeout: TIMEOUT_CYCLES = 8; m0 read; slave never asserts ready.
  - Expect m0_ready = 1, m0_rdata = 0 and timeout_pulse = 1 in the 8th BUSY cycle; s_valid = 0 that cycle; grant = 00 next cycle.
- Ready/timeout collision: TIMEOUT_CYCLES = 8; slave asserts ready with rdata 0xA5A5A5A5 exactly in the 8th BUSY cycle.
  - Expect m0_rdata = 0xA5A5A5A5 and timeout_pulse = 0.
- Reset mid-transfer: assert reset asynchronously (off the clock edge) while grant = 10 with s_valid high.
  - Expect s_valid, grant and m1_ready all 0 immediately.
  - After release, a simultaneous request grants m0 first.
